tt_sweep_ctrl: RTL

- Sequencer for one 3-input truth-table logic block, such as the 0xD2 gate.
- On `start`, it walks all 8 input combinations through the gate, waits a settle interval for each, and samples the gate output.
- It assembles the observed 8-bit truth table and compares it against an expected table.
- Sits between the test/config host and a single combinational gate instance; it is the only driver of that gate's inputs.

---
 rtl/tt_sweep_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/tt_sweep_ctrl.sv
// Truth-table sweep sequencer: drives all 8 input vectors into one 3-input gate and checks its output table.
// Optional macro TT_SWEEP_STOP_ON_FAIL_EN: abort at the first wrong bit and report it on fail_idx.
module tt_sweep_ctrl #(
  parameter logic [7:0]  EXPECTED = 8'hD2,
  parameter int unsigned SETTLE   = 4,
  parameter int unsigned WAIT_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  input  logic       dut_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] observed,
  output logic [7:0] mismatch
`ifdef TT_SWEEP_STOP_ON_FAIL_EN
  ,
  output logic [2:0] fail_idx
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam logic [WAIT_W-1:0] SETTLE_LAST = WAIT_W'(SETTLE - 1);

  state_t            state;
  logic [2:0]        idx;
  logic [WAIT_W-1:0] wait_cnt;

  logic [7:0] obs_nxt;
  logic [7:0] mm_nxt;
  logic       pass_nxt;
  logic       fail_now;
  logic       finish_now;

  assign {in1, in2, in3} = idx;

  // Result flags are formed from the table including the bit being sampled,
  // so pass/mismatch are already valid in the same cycle done is high.
  always_comb begin
    obs_nxt       = observed;
    obs_nxt[~idx] = dut_out;
    fail_now      = 1'b0;
`ifdef TT_SWEEP_STOP_ON_FAIL_EN
    fail_now      = (dut_out != EXPECTED[~idx]);
    mm_nxt        = obs_nxt ^ (EXPECTED & (8'hFF << ~idx));
`else
    mm_nxt        = obs_nxt ^ EXPECTED;
`endif
    pass_nxt      = !fail_now && (obs_nxt == EXPECTED);
    finish_now    = fail_now || (idx == 3'd7);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      idx      <= '0;
      wait_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      observed <= '0;
      mismatch <= '0;
`ifdef TT_SWEEP_STOP_ON_FAIL_EN
      fail_idx <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            idx      <= '0;
            wait_cnt <= '0;
            observed <= '0;
            pass     <= 1'b0;
            mismatch <= '0;
            busy     <= 1'b1;
`ifdef TT_SWEEP_STOP_ON_FAIL_EN
            fail_idx <= '0;
`endif
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (wait_cnt == SETTLE_LAST) state <= S_SAMPLE;
        end
        S_SAMPLE: begin
          observed <= obs_nxt;
          if (finish_now) begin
            done     <= 1'b1;
            pass     <= pass_nxt;
            mismatch <= mm_nxt;
`ifdef TT_SWEEP_STOP_ON_FAIL_EN
            if (fail_now) fail_idx <= idx;
`endif
            state    <= S_DONE;
          end else begin
            idx      <= idx + 1'b1;
            wait_cnt <= '0;
            state    <= S_WAIT;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
